// File: rtl/multi_tick_divider.sv
// multi_tick_divider: multi-channel programmable tick/clock divider; optional MTD_RESYNC_EN adds a resync input
module multi_tick_divider #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 32,
  parameter int DEFAULT_DIV = 50000000,
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MTD_RESYNC_EN
  input  logic                resync,
`endif
  input  logic [CHANNELS-1:0] en,
  input  logic                load_valid,
  input  logic [CH_W-1:0]     load_ch,
  input  logic [WIDTH-1:0]    load_div,
  output logic                load_ready,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] pending
);
  localparam int CH_N = 1 << CH_W;
  logic [WIDTH-1:0] count_q [CHANNELS];
  logic [WIDTH-1:0] count_d [CHANNELS];
  logic [WIDTH-1:0] active_q [CHANNELS];
  logic [WIDTH-1:0] active_d [CHANNELS];
  logic [WIDTH-1:0] pend_div_q [CHANNELS];
  logic [WIDTH-1:0] pend_div_d [CHANNELS];
  logic [CHANNELS-1:0] pending_q, pending_d, tick_q, tick_d, clk_out_q, clk_out_d, tc;
  logic [CH_N-1:0] pend_ext;
  // unimplemented channel codes read as not pending, so such requests are accepted and dropped
  assign pend_ext = CH_N'(pending_q);
  assign load_ready = !pend_ext[load_ch];
  assign tick = tick_q;
  assign clk_out = clk_out_q;
  assign pending = pending_q;
  // per-channel next state: count/terminal count, divisor swap at TC, divisor handshake
  always_comb begin
    count_d = count_q;
    active_d = active_q;
    pend_div_d = pend_div_q;
    pending_d = pending_q;
    tick_d = '0;
    clk_out_d = clk_out_q;
    tc = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tc[c] = en[c] && (count_q[c] == ((active_q[c] == '0) ? WIDTH'(1) : active_q[c]) - WIDTH'(1));
      count_d[c] = tc[c] ? '0 : en[c] ? count_q[c] + WIDTH'(1) : count_q[c];
      tick_d[c] = tc[c];
      clk_out_d[c] = clk_out_q[c] ^ tc[c];
      active_d[c] = (tc[c] && pending_q[c]) ? pend_div_q[c] : active_q[c];
      pending_d[c] = pending_q[c] && !tc[c];
      if (load_valid && load_ready && load_ch == CH_W'(c)) begin
        pend_div_d[c] = load_div;
        pending_d[c] = 1'b1;
      end
`ifdef MTD_RESYNC_EN
      if (resync) begin
        count_d[c] = '0;
        tick_d[c] = 1'b0;
        clk_out_d[c] = 1'b0;
      end
`endif
    end
  end
  // state registers with synchronous reset to the default divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        count_q[c] <= '0;
        active_q[c] <= WIDTH'(DEFAULT_DIV);
        pend_div_q[c] <= '0;
      end
      pending_q <= '0;
      tick_q <= '0;
      clk_out_q <= '0;
    end else begin
      count_q <= count_d;
      active_q <= active_d;
      pend_div_q <= pend_div_d;
      pending_q <= pending_d;
      tick_q <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end
endmodule
